// File: rtl/crpa_macc_pkg.sv
// Shared types and constants for the CRPA multiply-accumulate sequencer.
// MACC_LAT is the MACC pipeline depth: operand reg, multiplier reg, accumulator.
package crpa_macc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } macc_seq_state_t;

  localparam int MACC_LAT = 3;

endpackage

// File: rtl/macc_seq.sv
// Feeds LEN sample pairs per block into the MACC, then captures the sum 4 cycles after the
// last handshake; s_ready only in RUN, so upstream stalls outside RUN and gaps just stall.
module macc_seq
  import crpa_macc_pkg::*;
#(
  parameter int SIZEIN  = 16,
  parameter int SIZEACC = 48,
  parameter int LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [SIZEIN-1:0]    s_a,
  input  logic [SIZEIN-1:0]    s_b,
  output logic                 m_ce,
  output logic                 m_clr,
  output logic [SIZEIN-1:0]    m_a,
  output logic [SIZEIN-1:0]    m_b,
  output logic [2:0]           m_we,
  input  logic [SIZEACC-1:0]   m_accum,
  output logic                 res_valid,
  output logic [SIZEACC-1:0]   res_data
);

  macc_seq_state_t     state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          drn_q, drn_d;
  logic [MACC_LAT-2:0] we_dly_q;
  logic                res_valid_q;
  logic [SIZEACC-1:0]  res_data_q;

  logic start_ok;
  logic hs;
  logic drain_last;

  assign start_ok   = start && (state_q == IDLE);
  assign hs         = s_valid && (state_q == RUN);
  assign drain_last = (state_q == DRAIN) && (drn_q == 2'(MACC_LAT - 1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          drn_d   = '0;
          state_d = (len != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (s_valid) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            cnt_d   = '0;
            drn_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_last) begin
          drn_d   = '0;
          state_d = IDLE;
        end else begin
          drn_d = drn_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drn_q       <= '0;
      we_dly_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      // we[1]/we[2] trail the operand strobe so each stage fires exactly once per pair
      we_dly_q    <= {we_dly_q[MACC_LAT-3:0], hs};
      res_valid_q <= drain_last;
      if (drain_last) res_data_q <= m_accum;
    end
  end

  assign busy      = (state_q != IDLE);
  assign s_ready   = (state_q == RUN);
  assign m_ce      = 1'b1;
  assign m_clr     = start_ok;
  assign m_a       = s_a;
  assign m_b       = s_b;
  assign m_we      = {we_dly_q, hs};
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_macc_seq.sv
// Bench for macc_seq with a behavioural 3-stage MACC alongside; directed scenarios.
module tb_macc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_a;
  logic [15:0] s_b;
  logic        m_ce;
  logic        m_clr;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [2:0]  m_we;
  logic        res_valid;
  logic [47:0] res_data;

  logic signed [15:0] ma_q = '0;
  logic signed [15:0] mb_q = '0;
  logic signed [31:0] mp_q = '0;
  logic signed [47:0] macc_q = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int st_cyc = 0;
  int rv_cnt = 0;
  int rv_cyc = 0;
  int rdy_cnt = 0;
  int busy_drop = 0;
  bit watch_busy = 0;
  logic [47:0] rv_data = '0;

  always #5 clk = ~clk;

  macc_seq #(.SIZEIN(16), .SIZEACC(48), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .m_ce(m_ce), .m_clr(m_clr), .m_a(m_a), .m_b(m_b), .m_we(m_we),
    .m_accum(macc_q), .res_valid(res_valid), .res_data(res_data)
  );

  // Reference MACC: operand reg, multiplier reg, accumulator with clr priority
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_ce) begin
      if (m_we[0]) begin
        ma_q <= m_a;
        mb_q <= m_b;
      end
      if (m_we[1]) mp_q <= ma_q * mb_q;
      if (m_clr) macc_q <= '0;
      else if (m_we[2]) macc_q <= macc_q + {{16{mp_q[31]}}, mp_q};
    end
  end

  always @(negedge clk) begin
    if (s_valid === 1'b1 && s_ready === 1'b1) hs_cyc = cyc;
    if (s_ready === 1'b1) rdy_cnt++;
    if (res_valid === 1'b1) begin
      rv_cnt++;
      rv_cyc = cyc;
      rv_data = res_data;
      watch_busy = 0;
    end else if (watch_busy && busy !== 1'b1) begin
      busy_drop++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] l);
    start = 1'b1;
    len = l;
    @(negedge clk);
    st_cyc = cyc;
    total++;
    if (m_clr !== 1'b1) begin bad++; $display("FAIL start_clr got=%b want=1", m_clr); end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_pair(input logic signed [15:0] a, input logic signed [15:0] b);
    bit got;
    got = 0;
    s_a = a;
    s_b = b;
    s_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (s_ready === 1'b1);
    end
    total++;
    if (!got) begin bad++; $display("FAIL send_timeout got=no_ready want=ready"); end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", s_ready); end
    total++; if (m_we !== 3'b000) begin bad++; $display("FAIL rst_we got=%b want=000", m_we); end
    total++; if (m_clr !== 1'b0) begin bad++; $display("FAIL rst_clr got=%b want=0", m_clr); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b want=0", res_valid); end
    total++; if (res_data !== 48'd0) begin bad++; $display("FAIL rst_data got=%0d want=0", res_data); end
    total++; if (m_ce !== 1'b1) begin bad++; $display("FAIL rst_ce got=%b want=1", m_ce); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    int rv0;
    rv0 = rv_cnt;
    do_start(16'd4);
    send_pair(16'sd1, 16'sd5);
    send_pair(16'sd2, 16'sd6);
    send_pair(16'sd3, 16'sd7);
    send_pair(16'sd4, 16'sd8);
    idle(8);
    total++; if (rv_cnt !== rv0 + 1) begin bad++; $display("FAIL basic_count got=%0d want=%0d", rv_cnt - rv0, 1); end
    total++; if (rv_data !== 48'd70) begin bad++; $display("FAIL basic_data got=%0d want=70", $signed(rv_data)); end
    total++; if (rv_cyc - hs_cyc !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", rv_cyc - hs_cyc); end
  endtask

  task automatic test_gaps();
    int rv0;
    int bd0;
    logic signed [47:0] expv;
    expv = -48'sd220;
    rv0 = rv_cnt;
    bd0 = busy_drop;
    do_start(16'd3);
    watch_busy = 1;
    send_pair(-16'sd3, 16'sd7);
    idle(2);
    send_pair(16'sd100, -16'sd2);
    idle(2);
    send_pair(-16'sd1, -16'sd1);
    idle(8);
    total++; if (rv_cnt !== rv0 + 1) begin bad++; $display("FAIL gaps_count got=%0d want=1", rv_cnt - rv0); end
    total++; if (rv_data !== expv) begin bad++; $display("FAIL gaps_data got=%0d want=-220", $signed(rv_data)); end
    total++; if (busy_drop !== bd0) begin bad++; $display("FAIL gaps_busy got=%0d drops want=0", busy_drop - bd0); end
  endtask

  task automatic test_extremes();
    int rv0;
    rv0 = rv_cnt;
    do_start(16'd2);
    send_pair(16'sh8000, 16'sh8000);
    send_pair(16'sh8000, 16'sh8000);
    idle(8);
    total++; if (rv_cnt !== rv0 + 1) begin bad++; $display("FAIL ext_count got=%0d want=1", rv_cnt - rv0); end
    total++; if (rv_data !== 48'd2147483648) begin bad++; $display("FAIL ext_data got=%0d want=2147483648", $signed(rv_data)); end
  endtask

  task automatic test_len0();
    int rv0;
    int rdy0;
    rv0 = rv_cnt;
    rdy0 = rdy_cnt;
    do_start(16'd0);
    idle(8);
    total++; if (rv_cnt !== rv0 + 1) begin bad++; $display("FAIL len0_count got=%0d want=1", rv_cnt - rv0); end
    total++; if (rv_cyc - st_cyc !== 4) begin bad++; $display("FAIL len0_latency got=%0d want=4", rv_cyc - st_cyc); end
    total++; if (rv_data !== 48'd0) begin bad++; $display("FAIL len0_data got=%0d want=0", $signed(rv_data)); end
    total++; if (rdy_cnt !== rdy0) begin bad++; $display("FAIL len0_ready got=%0d cycles want=0", rdy_cnt - rdy0); end
  endtask

  task automatic test_back_to_back();
    int rv0;
    rv0 = rv_cnt;
    do_start(16'd2);
    send_pair(16'sd2, 16'sd3);
    start = 1'b1; len = 16'd0;
    @(negedge clk);
    total++; if (m_clr !== 1'b0) begin bad++; $display("FAIL run_start_clr got=%b want=0", m_clr); end
    @(posedge clk);
    #1;
    start = 1'b0;
    send_pair(16'sd4, 16'sd5);
    idle(1);
    start = 1'b1; len = 16'd0;
    @(negedge clk);
    total++; if (m_clr !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL drain_start got=clr%b/busy%b want=clr0/busy1", m_clr, busy); end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1; len = 16'd1;
    @(negedge clk);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL b2b_rv got=%b want=1", res_valid); end
    total++; if (res_data !== 48'd26) begin bad++; $display("FAIL b2b_first got=%0d want=26", $signed(res_data)); end
    total++; if (m_clr !== 1'b1) begin bad++; $display("FAIL b2b_clr got=%b want=1", m_clr); end
    @(posedge clk);
    #1;
    start = 1'b0;
    send_pair(16'sd3, 16'sd3);
    idle(8);
    total++; if (rv_cnt !== rv0 + 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", rv_cnt - rv0); end
    total++; if (rv_data !== 48'd9) begin bad++; $display("FAIL b2b_second got=%0d want=9", $signed(rv_data)); end
  endtask

  task automatic test_reset_mid();
    int rv0;
    logic signed [47:0] expv;
    expv = -48'sd6;
    rv0 = rv_cnt;
    do_start(16'd5);
    send_pair(16'sd10, 16'sd10);
    send_pair(16'sd10, 16'sd10);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0 || s_ready !== 1'b0) begin bad++; $display("FAIL mid_state got=busy%b/rdy%b want=0/0", busy, s_ready); end
    total++; if (m_we !== 3'b000) begin bad++; $display("FAIL mid_we got=%b want=000", m_we); end
    total++; if (res_valid !== 1'b0 || m_clr !== 1'b0) begin bad++; $display("FAIL mid_rv_clr got=%b/%b want=0/0", res_valid, m_clr); end
    total++; if (res_data !== 48'd0) begin bad++; $display("FAIL mid_data got=%0d want=0", res_data); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(8);
    total++; if (rv_cnt !== rv0) begin bad++; $display("FAIL mid_norv got=%0d want=0", rv_cnt - rv0); end
    do_start(16'd1);
    send_pair(16'sd3, -16'sd2);
    idle(8);
    total++; if (rv_cnt !== rv0 + 1) begin bad++; $display("FAIL mid_count got=%0d want=1", rv_cnt - rv0); end
    total++; if (rv_data !== expv) begin bad++; $display("FAIL mid_data2 got=%0d want=-6", $signed(rv_data)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_extremes();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
